// File: rtl/pdp8_major_state_seq_if.sv
// Bus bundle between the major-state sequencer and the IR / front panel / datapath.
// master drives the panel, IR and break requests; slave is the sequencer.
interface pdp8_major_state_seq_if #(
  parameter int NCHAN = 2
);
  logic             halt;
  logic             single_step;
  logic             cont;
  logic             trigger;
  logic             int_req;
  logic             int_ena;
  logic             int_inh;
  logic             uf;
  logic [0:11]      instruction;
  logic             index;
  logic             eae_start;
  logic             eae_loop;
  logic [NCHAN-1:0] db_req;
  logic [NCHAN-1:0] db_grant;
  logic             break_in_prog;
  logic             int_in_prog;
  logic [4:0]       state;

  modport master (
    output halt, single_step, cont, trigger, int_req, int_ena, int_inh, uf,
           instruction, index, eae_start, eae_loop, db_req,
    input  db_grant, break_in_prog, int_in_prog, state
  );

  modport slave (
    input  halt, single_step, cont, trigger, int_req, int_ena, int_inh, uf,
           instruction, index, eae_start, eae_loop, db_req,
    output db_grant, break_in_prog, int_in_prog, state
  );
endinterface

// File: rtl/pdp8_major_state_seq.sv
// PDP-8/e major-state sequencer: fetch/defer/execute/halt/EAE cycles plus
// NCHAN arbitrated data-break channels that preempt and then resume a cycle.
module pdp8_major_state_seq #(
  parameter int NCHAN       = 2,
  parameter int WAIT_STATES = 1,
  parameter int RR          = 0
) (
  input logic                   clk,
  input logic                   reset,
  pdp8_major_state_seq_if.slave bus
);
  localparam logic [4:0] S_F0 = 5'd0,   S_FW = 5'd1,   S_F1 = 5'd2,   S_F2 = 5'd3;
  localparam logic [4:0] S_F3 = 5'd4,   S_D0 = 5'd5,   S_DW = 5'd6,   S_D1 = 5'd7;
  localparam logic [4:0] S_D2 = 5'd8,   S_D3 = 5'd9,   S_E0 = 5'd10,  S_EW = 5'd11;
  localparam logic [4:0] S_E1 = 5'd12,  S_E2 = 5'd13,  S_E3 = 5'd14,  S_H0 = 5'd15;
  localparam logic [4:0] S_HW = 5'd16,  S_H1 = 5'd17,  S_H2 = 5'd18,  S_H3 = 5'd19;
  localparam logic [4:0] S_EAE0 = 5'd20, S_EAE1 = 5'd21, S_DB0 = 5'd22, S_DBW = 5'd23;
  localparam logic [4:0] S_DB1 = 5'd24, S_DB2 = 5'd25, S_DB3 = 5'd26;

  localparam int         PW        = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES - 1);

  logic [4:0]       state_q, state_d, resume_q, resume_d;
  logic [NCHAN-1:0] grant_q, grant_d, win;
  logic [PW-1:0]    ptr_q, win_idx, g_idx, ptr_step;
  logic [2:0]       wait_cnt;
  logic             iip_q, iip_d, eae_e1_q, eae_e1_d, bip_q;
  logic             irq, brk, stall, wait_done, in_wait, hlt_op, found;
  logic [2:0]       opcode;

  assign irq       = bus.int_req & bus.int_ena & ~bus.int_inh;
  assign brk       = |bus.db_req;
  assign stall     = bus.single_step & ~bus.cont;
  assign opcode    = bus.instruction[0:2];
  assign hlt_op    = (bus.instruction[0:3] == 4'b1111) &&
                     (bus.instruction[10:11] == 2'b10) && !bus.uf;
  assign in_wait   = (state_q == S_FW) || (state_q == S_DW) ||
                     (state_q == S_EW) || (state_q == S_DBW);
  assign wait_done = (wait_cnt == WAIT_LAST);

  // Round-robin first scans from the pointer upward; the unconditional second
  // pass supplies both the wrap-around and the fixed-priority case.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    if (RR != 0) begin
      for (int i = 0; i < NCHAN; i++) begin
        if (!found && bus.db_req[i] && (i >= int'(ptr_q))) begin
          found   = 1'b1;
          win_idx = PW'(i);
        end
      end
    end
    for (int i = 0; i < NCHAN; i++) begin
      if (!found && bus.db_req[i]) begin
        found   = 1'b1;
        win_idx = PW'(i);
      end
    end
    for (int i = 0; i < NCHAN; i++) win[i] = found && (win_idx == PW'(i));
  end

  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NCHAN; i++) if (grant_q[i]) g_idx = PW'(i);
    ptr_step = (g_idx == PW'(NCHAN - 1)) ? '0 : g_idx + 1'b1;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = S_H0;
    resume_d = resume_q;
    grant_d  = grant_q;
    iip_d    = iip_q;
    eae_e1_d = eae_e1_q;
    if (brk && (state_q == S_F0 || state_q == S_E0 || state_q == S_HW)) begin
      state_d  = S_DB0;
      grant_d  = win;
      resume_d = (state_q == S_HW) ? S_H0 : state_q;
    end else begin
      case (state_q)
        S_F0:   if (stall) state_d = S_F0;
                else if (bus.halt && !bus.cont) state_d = S_H0;
                else state_d = S_FW;
        S_FW:   state_d = wait_done ? S_F1 : S_FW;
        S_F1:   state_d = S_F2;
        S_F2:   if (bus.eae_start) begin
                  state_d  = S_EAE0;
                  eae_e1_d = 1'b0;
                end else state_d = S_F3;
        S_F3:   if (opcode[2:1] == 2'b11) begin
                  if (hlt_op) state_d = S_H0;
                  else if (irq && bus.instruction != 12'o6002) begin
                    iip_d   = 1'b1;
                    state_d = S_E0;
                  end else state_d = S_F0;
                end else if (bus.instruction[3]) state_d = S_D0;
                else if (opcode == 3'd5) begin
                  if (irq) begin
                    iip_d   = 1'b1;
                    state_d = S_E0;
                  end else state_d = S_F0;
                end else state_d = S_E0;
        S_D0:   state_d = stall ? S_D0 : S_DW;
        S_DW:   state_d = !wait_done ? S_DW : (bus.index ? S_D1 : S_D3);
        S_D1:   state_d = S_D2;
        S_D2:   state_d = S_D3;
        S_D3:   if (opcode == 3'd5) begin
                  if (irq) begin
                    iip_d   = 1'b1;
                    state_d = S_E0;
                  end else state_d = S_F0;
                end else state_d = S_E0;
        S_E0:   state_d = stall ? S_E0 : S_EW;
        S_EW:   state_d = wait_done ? S_E1 : S_EW;
        S_E1:   if (bus.eae_start) begin
                  state_d  = S_EAE0;
                  eae_e1_d = 1'b1;
                end else state_d = S_E2;
        S_E2:   state_d = S_E3;
        S_E3:   if (irq && !iip_q) begin
                  iip_d   = 1'b1;
                  state_d = S_E0;
                end else state_d = S_F0;
        S_EAE0: state_d = S_EAE1;
        S_EAE1: state_d = bus.eae_loop ? S_EAE1 : (eae_e1_q ? S_E2 : S_F3);
        S_H0:   state_d = S_HW;
        S_HW:   if (bus.trigger && !bus.cont) state_d = S_H1;
                else if (!bus.cont) state_d = S_H0;
                else state_d = S_F0;
        S_H1:   state_d = S_H2;
        S_H2:   state_d = S_H3;
        S_H3:   state_d = S_H0;
        S_DB0:  state_d = S_DBW;
        S_DBW:  state_d = wait_done ? S_DB1 : S_DBW;
        S_DB1:  state_d = S_DB2;
        S_DB2:  state_d = S_DB3;
        S_DB3:  begin
                  state_d = resume_q;
                  grant_d = '0;
                end
        default: state_d = S_H0;
      endcase
    end
    if (state_q == S_F0 && state_d != S_F0) iip_d = 1'b0;
  end

  // NOTE: registered state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_H0;
      resume_q <= S_H0;
      grant_q  <= '0;
      ptr_q    <= '0;
      wait_cnt <= 3'd0;
      iip_q    <= 1'b0;
      eae_e1_q <= 1'b0;
      bip_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      grant_q  <= grant_d;
      iip_q    <= iip_d;
      eae_e1_q <= eae_e1_d;
      bip_q    <= (state_d >= S_DB0) && (state_d <= S_DB3);
      wait_cnt <= (in_wait && !wait_done) ? wait_cnt + 3'd1 : 3'd0;
      if (state_q == S_DB0) ptr_q <= ptr_step;
    end
  end

  assign bus.state         = state_q;
  assign bus.db_grant      = grant_q;
  assign bus.int_in_prog   = iip_q;
  assign bus.break_in_prog = bip_q;
endmodule
